// File: rtl/det_stream_pkg.sv
// -------------------------------------------------------------------------
// det_stream_pkg: shared state encodings and helpers for det_stream_sched
// Revision: 1.0
// -------------------------------------------------------------------------
`default_nettype none

package det_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    DET_S0 = 2'd0,
    DET_S1 = 2'd1,
    DET_S2 = 2'd2
  } det_state_t;

  // Never returns less than 1 so a requester index always has a bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/det_stream_sched_if.sv
// -------------------------------------------------------------------------
// det_stream_sched_if: requester bundle and per-frame result bus
// Revision: 1.0
// -------------------------------------------------------------------------
`default_nettype none

interface det_stream_sched_if #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  localparam int ID_W = det_stream_pkg::clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       bits;
  logic [N_REQ*LEN_W-1:0] lens;
  logic [N_REQ-1:0]       gnt;
  logic                   bit_rd;
  logic                   hit;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       hit_cnt;
  logic                   aborted;

  modport slave (
    input  req, bits, lens,
    output gnt, bit_rd, hit, done, done_id, hit_cnt, aborted
  );

  modport master (
    output req, bits, lens,
    input  gnt, bit_rd, hit, done, done_id, hit_cnt, aborted
  );

endinterface

`default_nettype wire

// File: rtl/det_stream_sched_pair_det.sv
// -------------------------------------------------------------------------
// pair_det: 3-state Mealy detector for overlapping "11" after a leading 1
// Revision: 1.0
// -------------------------------------------------------------------------
`default_nettype none

module pair_det
  import det_stream_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic x,
  output logic hit
);

  det_state_t r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DET_S0;
    end else if (clr) begin
      r_state <= DET_S0;
    end else if (en) begin
      case (r_state)
        DET_S0:  r_state <= x ? DET_S1 : DET_S0;
        DET_S1:  r_state <= x ? DET_S2 : DET_S0;
        DET_S2:  r_state <= x ? DET_S2 : DET_S0;
        default: r_state <= DET_S0;
      endcase
    end
  end

  assign hit = en && (r_state == DET_S2) && x;

endmodule

`default_nettype wire

// File: rtl/det_stream_sched.sv
// -------------------------------------------------------------------------
// det_stream_sched: round-robin scheduler sharing one detector among N streams
// Revision: 1.0
// -------------------------------------------------------------------------
`default_nettype none

module det_stream_sched
  import det_stream_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  det_stream_sched_if.slave bus
);

  localparam int               ID_W      = clog2(N_REQ);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [N_REQ-1:0] C_ONE     = N_REQ'(1);

  sched_state_t     r_state;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_rr;
  logic [ID_W-1:0]  r_done_id;
  logic [LEN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_aborted;

  logic [ID_W-1:0]  w_pick;
  logic             w_found;
  logic [LEN_W-1:0] w_len;
  logic             w_bit_rd;
  logic             w_clr;
  logic             w_bit;
  logic             w_hit;

  // First requester at or after the rr pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_rr) + k) % N_REQ;
      if (!w_found && bus.req[idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(idx);
      end
    end
  end

  assign w_len    = bus.lens[int'(w_pick)*LEN_W +: LEN_W];
  assign w_bit_rd = (r_state == ST_RUN) && bus.req[r_id];
  assign w_clr    = (r_state == ST_GRANT);
  assign w_bit    = bus.bits[r_id];

  pair_det u_det (
    .clk (clk),
    .rst (rst),
    .en  (w_bit_rd),
    .clr (w_clr),
    .x   (w_bit),
    .hit (w_hit)
  );

  always_comb begin
    bus.gnt = '0;
    if (r_state == ST_GRANT && w_found) begin
      bus.gnt = C_ONE << w_pick;
    end else if (r_state == ST_RUN || r_state == ST_DONE) begin
      bus.gnt = C_ONE << r_id;
    end
  end

  assign bus.bit_rd  = w_bit_rd;
  assign bus.hit     = w_hit;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.hit_cnt = r_cnt;
  assign bus.aborted = r_aborted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_id      <= '0;
      r_rr      <= '0;
      r_done_id <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) r_state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (w_found) begin
            r_id      <= w_pick;
            r_rem     <= w_len;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
            if (w_len != '0) begin
              r_state <= ST_RUN;
            end else begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_done_id <= w_pick;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!bus.req[r_id]) begin
            r_aborted <= 1'b1;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_done_id <= r_id;
          end else begin
            r_rem <= r_rem - LEN_W'(1);
            if (w_hit && r_cnt != C_CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_done_id <= r_id;
            end
          end
        end
        ST_DONE: begin
          r_rr    <= (int'(r_id) == N_REQ - 1) ? '0 : r_id + ID_W'(1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_det_stream_sched.sv
// -------------------------------------------------------------------------
// tb_det_stream_sched: directed and random frames against a frame-level model
// Revision: 1.0
// -------------------------------------------------------------------------
`default_nettype none

module tb_det_stream_sched;
  import det_stream_pkg::*;

  localparam int N     = 4;
  localparam int LW    = 8;
  localparam int CW    = 8;
  localparam int CW2   = 2;
  localparam int MAX_A = (1 << CW) - 1;
  localparam int MAX_B = (1 << CW2) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  det_stream_sched_if #(.N_REQ(N), .LEN_W(LW), .CNT_W(CW))  bus_a ();
  det_stream_sched_if #(.N_REQ(N), .LEN_W(LW), .CNT_W(CW2)) bus_b ();

  det_stream_sched #(.N_REQ(N), .LEN_W(LW), .CNT_W(CW))  dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  det_stream_sched #(.N_REQ(N), .LEN_W(LW), .CNT_W(CW2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // Source and frame model: each requester streams fb[i] LSB-first.
  logic [31:0] fb [N];
  int fl [N];
  int p [N];
  int abort_at [N];
  int rr_m = 0, cur = -1, c = 0, elen = 0, chits = 0, wait_cyc = 0;
  bit ended = 0, adv = 0, rand_mode = 0;
  int drop_pending = -1;
  int order [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit_rule(input int i, input int idx);
    if (idx < 2) return 1'b0;
    return fb[i][idx] && fb[i][idx-1] && fb[i][idx-2];
  endfunction

  task automatic start_frame(input int i, input int len, input logic [31:0] bv, input int ab);
    fb[i] = bv;
    fl[i] = len;
    p[i] = 0;
    abort_at[i] = ab;
    if (drop_pending == i) drop_pending = -1;
    bus_a.lens[i*LW +: LW] = LW'(len);
    bus_a.bits[i] = bv[0];
    bus_a.req[i] = 1'b1;
  endtask

  task automatic tick();
    int e;
    bit exp_hit;
    int exp_cnt;
    @(posedge clk);
    #1;
    if (adv) begin
      p[cur]++;
      adv = 0;
    end
    if (drop_pending >= 0) begin
      bus_a.req[drop_pending] = 1'b0;
      drop_pending = -1;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (i != cur && !bus_a.req[i] && $urandom_range(0, 3) == 0) begin
          int len;
          len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
          start_frame(i, len, $urandom,
                      (len > 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, len - 1)) : -1);
        end
      end
      if (cur >= 0) bus_a.lens[cur*LW +: LW] = LW'($urandom);
    end
    for (int i = 0; i < N; i++) bus_a.bits[i] = fb[i][p[i]];
    #1;
    chk("gnt_onehot0", 32'($onehot0(bus_a.gnt)), 1);
    if (cur < 0) begin
      if (bus_a.gnt != '0) begin
        e = -1;
        for (int j = 0; j < N; j++) begin
          if (e < 0 && bus_a.req[(rr_m + j) % N]) e = (rr_m + j) % N;
        end
        chk("grant_pick", bus_a.gnt, (e < 0) ? 0 : (32'(1) << e));
        chk("grant_bit_rd", bus_a.bit_rd, 0);
        chk("grant_done", bus_a.done, 0);
        if (e >= 0) begin
          cur = e; c = 0; chits = 0; ended = 0; elen = fl[e];
        end
        wait_cyc = 0;
      end else begin
        chk("idle_bit_rd", bus_a.bit_rd, 0);
        chk("idle_done", bus_a.done, 0);
        if (bus_a.req != '0) wait_cyc++;
        if (wait_cyc > 3) begin
          chk("grant_timeout", wait_cyc, 0);
          wait_cyc = 0;
        end
      end
    end else begin
      chk("gnt_hold", bus_a.gnt, 32'(1) << cur);
      if (ended || c == elen) begin
        exp_cnt = (chits > MAX_A) ? MAX_A : chits;
        chk("done_pulse", bus_a.done, 1);
        chk("done_id", bus_a.done_id, cur);
        chk("done_hit_cnt", bus_a.hit_cnt, exp_cnt);
        chk("done_aborted", bus_a.aborted, (c < elen) ? 1 : 0);
        chk("done_bit_rd", bus_a.bit_rd, 0);
        order.push_back(cur);
        rr_m = (cur + 1) % N;
        drop_pending = cur;
        cur = -1;
        wait_cyc = 0;
      end else if (!bus_a.req[cur]) begin
        ended = 1;
        chk("abort_bit_rd", bus_a.bit_rd, 0);
        chk("abort_hit", bus_a.hit, 0);
        chk("abort_done", bus_a.done, 0);
      end else begin
        exp_hit = hit_rule(cur, c);
        chk("run_bit_rd", bus_a.bit_rd, 1);
        chk("run_hit", bus_a.hit, exp_hit);
        chk("run_done", bus_a.done, 0);
        if (exp_hit) chits++;
        c++;
        adv = 1;
        if (abort_at[cur] == c) drop_pending = cur;
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((cur >= 0 || bus_a.req != '0 || drop_pending >= 0) && n < bound) begin
      tick();
      n++;
    end
    chk("reach_idle", 32'(cur >= 0 || bus_a.req != '0), 0);
  endtask

  initial begin
    logic [7:0] ones;
    int raw, rd_b;
    bit got;
    bus_a.req = '0; bus_a.bits = '0; bus_a.lens = '0;
    bus_b.req = '0; bus_b.bits = '0; bus_b.lens = '0;
    for (int i = 0; i < N; i++) begin
      fb[i] = '0; fl[i] = 0; p[i] = 0; abort_at[i] = -1;
    end

    #1;
    chk("rst_gnt", bus_a.gnt, 0);
    chk("rst_bit_rd", bus_a.bit_rd, 0);
    chk("rst_hit", bus_a.hit, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_done_id", bus_a.done_id, 0);
    chk("rst_hit_cnt", bus_a.hit_cnt, 0);
    chk("rst_aborted", bus_a.aborted, 0);
    @(negedge clk);
    rst = 1'b1;

    // Requesters 1 and 3 from reset: expect 1, 3, then 1 again.
    order.delete();
    start_frame(1, 3, 32'b101, -1);
    start_frame(3, 3, 32'b011, -1);
    for (int n = 0; n < 50 && order.size() < 1; n++) tick();
    start_frame(1, 2, 32'b11, -1);
    wait_idle(100);
    chk("rr_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("rr_first", order[0], 1);
      chk("rr_second", order[1], 3);
      chk("rr_third", order[2], 1);
    end

    start_frame(0, 6, 32'b101110, -1);
    wait_idle(50);
    start_frame(2, 0, 32'hFFFF_FFFF, -1);
    wait_idle(50);
    start_frame(0, 2, 32'b11, -1);
    wait_idle(50);
    start_frame(0, 2, 32'b11, -1);
    wait_idle(50);
    start_frame(0, 10, 32'h3FF, 3);
    wait_idle(50);

    rand_mode = 1;
    repeat (1500) tick();
    rand_mode = 0;
    wait_idle(800);

    // Asynchronous reset in the middle of a frame.
    start_frame(0, 10, 32'hFFFF_FFFF, -1);
    for (int n = 0; n < 30 && !(cur == 0 && c >= 3); n++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt", bus_a.gnt, 0);
    chk("arst_bit_rd", bus_a.bit_rd, 0);
    chk("arst_hit", bus_a.hit, 0);
    chk("arst_done", bus_a.done, 0);
    chk("arst_hit_cnt", bus_a.hit_cnt, 0);
    chk("arst_done_id", bus_a.done_id, 0);
    chk("arst_aborted", bus_a.aborted, 0);
    bus_a.req = '0;
    cur = -1; rr_m = 0; adv = 0; drop_pending = -1; wait_cyc = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("arst_hold_done", bus_a.done, 0);
    end
    rst = 1'b1;
    repeat (3) tick();
    start_frame(2, 4, 32'b1111, -1);
    wait_idle(50);

    // Narrow counter: eight ones must saturate.
    ones = '1;
    raw = 0;
    for (int idx = 2; idx < 8; idx++) if (ones[idx] && ones[idx-1] && ones[idx-2]) raw++;
    bus_b.lens[0 +: LW] = 8'd8;
    bus_b.bits = '1;
    bus_b.req = 4'b0001;
    rd_b = 0;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus_b.bit_rd) rd_b++;
      if (bus_b.done) begin
        got = 1;
        chk("sat_hit_cnt", bus_b.hit_cnt, (raw > MAX_B) ? MAX_B : raw);
        chk("sat_aborted", bus_b.aborted, 0);
        chk("sat_done_id", bus_b.done_id, 0);
      end
    end
    bus_b.req = '0;
    chk("sat_done_seen", got, 1);
    chk("sat_bit_rd_cycles", rd_b, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
